// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling off the system clock,
// valid/ready word output with framing and overrun pulses.
module uart_rx #(
   parameter int SYS_CLK_FREQ = 1_000_000,
   parameter int BAUD_RATE    = 9600,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  areset_n,
   input  logic                  sreset_n,
   input  logic                  rx_in,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  framing_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W        = $clog2(DATA_WIDTH) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_prev;
   logic [1:0]            r_arm;
   logic                  r_armed;
   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [IDX_W-1:0]      r_bit_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_ferr;
   logic                  r_ovr;

   logic                  w_sync1;
   logic                  w_sync2;
   logic                  w_prev;
   logic [1:0]            w_arm;
   logic                  w_armed;
   logic [1:0]            w_state;
   logic [CNT_W-1:0]      w_bit_cnt;
   logic [IDX_W-1:0]      w_bit_idx;
   logic [DATA_WIDTH-1:0] w_shift;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_valid;
   logic                  w_ferr;
   logic                  w_ovr;
   logic                  w_fall;
   logic                  w_word_ok;

   always_comb begin
      w_sync1   = rx_in;
      w_sync2   = r_sync1;
      w_prev    = r_sync2;
      // Edges count only once the chain holds real line samples and the
      // line has been seen high, so a line stuck low after reset never starts
      w_arm     = {r_arm[0], 1'b1};
      w_armed   = r_armed | (r_arm[1] & r_sync2);
      w_fall    = r_armed & r_prev & ~r_sync2;
      w_state   = r_state;
      w_bit_cnt = r_bit_cnt + CNT_ONE;
      w_bit_idx = r_bit_idx;
      w_shift   = r_shift;
      w_word_ok = 1'b0;
      w_ferr    = 1'b0;
      w_ovr     = 1'b0;
      w_data    = r_data;
      w_valid   = r_valid;

      unique case (1'b1)
         (r_state == S_IDLE): begin
            w_bit_cnt = '0;
            if (w_fall) w_state = S_START;
         end
         (r_state == S_START): begin
            if (r_bit_cnt == CNT_HALF) begin
               w_bit_cnt = '0;
               w_bit_idx = '0;
               w_state   = r_sync2 ? S_IDLE : S_DATA;
            end
         end
         (r_state == S_DATA): begin
            if (r_bit_cnt == CNT_LAST) begin
               w_bit_cnt = '0;
               w_shift   = {r_sync2, r_shift[DATA_WIDTH-1:1]};
               if (r_bit_idx == IDX_LAST) w_state = S_STOP;
               else w_bit_idx = r_bit_idx + IDX_ONE;
            end
         end
         (r_state == S_STOP): begin
            if (r_bit_cnt == CNT_LAST) begin
               w_bit_cnt = '0;
               w_state   = S_IDLE;
               w_word_ok = r_sync2;
               w_ferr    = ~r_sync2;
            end
         end
         default: w_state = S_IDLE;
      endcase

      if (w_word_ok) begin
         if (!r_valid || data_ready) begin
            w_data  = r_shift;
            w_valid = 1'b1;
         end else begin
            w_ovr = 1'b1;
         end
      end else if (r_valid && data_ready) begin
         w_valid = 1'b0;
      end

      if (!sreset_n) begin
         w_sync1   = 1'b1;
         w_sync2   = 1'b1;
         w_prev    = 1'b1;
         w_arm     = '0;
         w_armed   = 1'b0;
         w_state   = S_IDLE;
         w_bit_cnt = '0;
         w_bit_idx = '0;
         w_shift   = '0;
         w_data    = '0;
         w_valid   = 1'b0;
         w_ferr    = 1'b0;
         w_ovr     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_prev    <= 1'b1;
         r_arm     <= '0;
         r_armed   <= 1'b0;
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_sync1   <= w_sync1;
         r_sync2   <= w_sync2;
         r_prev    <= w_prev;
         r_arm     <= w_arm;
         r_armed   <= w_armed;
         r_state   <= w_state;
         r_bit_cnt <= w_bit_cnt;
         r_bit_idx <= w_bit_idx;
         r_shift   <= w_shift;
         r_data    <= w_data;
         r_valid   <= w_valid;
         r_ferr    <= w_ferr;
         r_ovr     <= w_ovr;
      end
   end

   assign data        = r_data;
   assign data_valid  = r_valid;
   assign framing_err = r_ferr;
   assign overrun     = r_ovr;
   assign busy        = (r_state != S_IDLE);

endmodule
